throttle_axis_ramp: RTL and testbench

Multi-channel thrust-lever emulator between the `hps_io` joystick outputs and a core's analog `THRUST` input. Converts either a signed analog stick axis or digital up/down keys into a saturated unsigned lever position, one independent register per channel. A shared prescaler sets the ramp rate. Each channel has a run-time mode: absolute analog, D-pad ramp, analog rate, or spring-return D-pad.

---
 rtl/throttle_axis_ramp.sv | 158 +++++++++++++++
 tb/tb_throttle_axis_ramp.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/throttle_axis_ramp.sv
// throttle_axis_ramp: multi-channel thrust-lever emulator.
// Each channel turns a signed stick axis or up/down keys into a saturated
// unsigned lever position. A shared free-running prescaler sets the ramp rate
// of the relative modes; absolute mode reloads every clock.
module throttle_axis_ramp #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 254,
    parameter int TICK_DIV = 196850,
    parameter int DEADZONE = 8
) (
    input  logic                      clk_sys,
    input  logic                      RESET_L,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic [CHANNELS-1:0]       key_up,
    input  logic [CHANNELS-1:0]       key_down,
    input  logic [8*CHANNELS-1:0]     axis,
    output logic [WIDTH*CHANNELS-1:0] thrust,
    output logic [CHANNELS-1:0]       at_max,
    output logic [CHANNELS-1:0]       at_min,
    output logic                      tick
);

    // Arithmetic width: two guard bits give room for the sign and for an
    // overshoot past MAX_VAL before saturation.
    localparam int SW = WIDTH + 2;
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CW-1:0]        CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0]     MAX_W    = WIDTH'(MAX_VAL);
    localparam logic [SW-1:0]        MAX_U    = SW'(MAX_VAL);
    localparam logic signed [SW-1:0] MAX_S    = SW'(MAX_VAL);
    localparam logic signed [SW-1:0] STEP_P1  = SW'(1);
    localparam logic signed [SW-1:0] STEP_M1  = SW'(-1);
    localparam logic signed [SW-1:0] STEP_M2  = SW'(-2);
    localparam logic [8:0]           DZ       = 9'(DEADZONE);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Prescaler next count: wraps to zero after TICK_DIV-1.
    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    end

    // Prescaler register; never disturbed by mode changes.
    always_ff @(posedge clk_sys or negedge RESET_L) begin
        if (!RESET_L) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [1:0]              mode_c;
        logic                    up_c;
        logic                    dn_c;
        logic [7:0]              axis_c;
        logic signed [8:0]       axis_x;
        logic signed [8:0]       raw_abs;
        logic [8:0]              mag;
        logic [SW-1:0]           abs_scaled;
        logic [WIDTH-1:0]        abs_val;
        logic signed [SW-1:0]    step;
        logic signed [SW-1:0]    delta;
        logic signed [SW-1:0]    sum;
        logic [WIDTH-1:0]        rel_val;
        logic [WIDTH-1:0]        thr_q;
        logic [WIDTH-1:0]        thr_d;
        logic                    at_max_q;
        logic                    at_min_q;

        assign mode_c = mode[2*gi +: 2];
        assign up_c   = key_up[gi];
        assign dn_c   = key_down[gi];
        assign axis_c = axis[8*gi +: 8];

        // Absolute mapping: stick up (negative) gives more thrust.
        always_comb begin
            axis_x     = {axis_c[7], axis_c};
            raw_abs    = 9'sd127 - axis_x;
            abs_scaled = SW'(raw_abs[7:0]) << (WIDTH - 8);
            abs_val    = (abs_scaled > MAX_U) ? MAX_W : abs_scaled[WIDTH-1:0];
        end

        // Relative step for the current mode, applied on a tick and saturated.
        always_comb begin
            mag   = axis_x[8] ? (9'd0 - axis_x) : axis_x;
            step  = SW'(mag[8:4]) + STEP_P1;
            delta = '0;
            case (mode_c)
                2'b01: begin
                    if (up_c && !dn_c) begin
                        delta = STEP_P1;
                    end else if (dn_c && !up_c) begin
                        delta = STEP_M1;
                    end
                end
                2'b10: begin
                    if (mag > DZ) begin
                        delta = axis_x[8] ? step : -step;
                    end
                end
                2'b11: begin
                    if (up_c && dn_c) begin
                        delta = '0;
                    end else if (up_c) begin
                        delta = STEP_P1;
                    end else if (dn_c) begin
                        delta = STEP_M2;
                    end else begin
                        delta = STEP_M1;
                    end
                end
                default: delta = '0;
            endcase
            sum = signed'(SW'(thr_q)) + delta;
            if (sum < 0) begin
                rel_val = '0;
            end else if (sum > MAX_S) begin
                rel_val = MAX_W;
            end else begin
                rel_val = sum[WIDTH-1:0];
            end
        end

        // Next lever value: absolute reloads every cycle, relative only on tick.
        always_comb begin
            thr_d = thr_q;
            if (mode_c == 2'b00) begin
                thr_d = abs_val;
            end else if (tick) begin
                thr_d = rel_val;
            end
        end

        // Lever register with end-stop flags decoded from the next value.
        always_ff @(posedge clk_sys or negedge RESET_L) begin
            if (!RESET_L) begin
                thr_q    <= '0;
                at_max_q <= 1'b0;
                at_min_q <= 1'b1;
            end else begin
                thr_q    <= thr_d;
                at_max_q <= (thr_d == MAX_W);
                at_min_q <= (thr_d == '0);
            end
        end

        assign thrust[WIDTH*gi +: WIDTH] = thr_q;
        assign at_max[gi]                = at_max_q;
        assign at_min[gi]                = at_min_q;
    end

endmodule

// File: tb/tb_throttle_axis_ramp.sv
// Testbench for throttle_axis_ramp: table of absolute mappings, hand-written
// ramp/rate/spring sequences and randomized traffic against an integer model.
module tb_throttle_axis_ramp;

    localparam int TD   = 4;
    localparam int W    = 8;
    localparam int MX   = 254;
    localparam int DZN  = 8;
    localparam int NCH  = 2;
    localparam int WB   = 10;
    localparam int MXB  = 1000;

    logic             clk_sys = 1'b0;
    logic             RESET_L;
    logic [2*NCH-1:0] mode;
    logic [NCH-1:0]   key_up;
    logic [NCH-1:0]   key_down;
    logic [8*NCH-1:0] axis;
    logic [W*NCH-1:0] thrust;
    logic [NCH-1:0]   at_max;
    logic [NCH-1:0]   at_min;
    logic             tick;

    logic [1:0]       mode_b;
    logic [0:0]       key_up_b;
    logic [0:0]       key_down_b;
    logic [7:0]       axis_b;
    logic [WB-1:0]    thrust_b;
    logic [0:0]       at_max_b;
    logic [0:0]       at_min_b;
    logic             tick_b;

    throttle_axis_ramp #(.CHANNELS(NCH), .WIDTH(W), .MAX_VAL(MX), .TICK_DIV(TD), .DEADZONE(DZN)) dut (
        .clk_sys(clk_sys), .RESET_L(RESET_L), .mode(mode), .key_up(key_up), .key_down(key_down),
        .axis(axis), .thrust(thrust), .at_max(at_max), .at_min(at_min), .tick(tick)
    );

    throttle_axis_ramp #(.CHANNELS(1), .WIDTH(WB), .MAX_VAL(MXB), .TICK_DIV(TD), .DEADZONE(DZN)) dut_b (
        .clk_sys(clk_sys), .RESET_L(RESET_L), .mode(mode_b), .key_up(key_up_b), .key_down(key_down_b),
        .axis(axis_b), .thrust(thrust_b), .at_max(at_max_b), .at_min(at_min_b), .tick(tick_b)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int ax;
        int exp8;
        int exp10;
    } abs_vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mv[NCH];
    int mvb;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clampv(input int v, input int mx);
        if (v < 0) return 0;
        if (v > mx) return mx;
        return v;
    endfunction

    // Lever behaviour straight from the rules: integer arithmetic, then clamp.
    function automatic int model_next(input int v, input int md, input bit up, input bit dn,
                                      input int ax, input bit tk, input int w, input int mx);
        int d = 0;
        int m;
        if (md == 0) return clampv((127 - ax) * (1 << (w - 8)), mx);
        if (!tk) return v;
        case (md)
            1: d = (up && !dn) ? 1 : ((dn && !up) ? -1 : 0);
            2: begin
                m = (ax < 0) ? -ax : ax;
                if (m > DZN) d = (ax < 0) ? (m / 16 + 1) : -(m / 16 + 1);
            end
            default: d = (up && dn) ? 0 : (up ? 1 : (dn ? -2 : -1));
        endcase
        return clampv(v + d, mx);
    endfunction

    function automatic int th(input int ch);
        return int'(thrust[W*ch +: W]);
    endfunction

    task automatic set_axis(input int ch, input int v);
        axis[8*ch +: 8] = 8'(v);
    endtask

    // One clock: predict, clock, compare everything, return at the negedge.
    task automatic cycle();
        bit tk;
        tk = ((cyc % TD) == TD - 1);
        check("tick", int'(tick), int'(tk));
        check("tick_b", int'(tick_b), int'(tk));
        for (int ch = 0; ch < NCH; ch++) begin
            mv[ch] = model_next(mv[ch], int'(mode[2*ch +: 2]), key_up[ch], key_down[ch],
                                int'($signed(axis[8*ch +: 8])), tk, W, MX);
        end
        mvb = model_next(mvb, int'(mode_b), key_up_b[0], key_down_b[0], int'($signed(axis_b)), tk, WB, MXB);
        @(posedge clk_sys);
        #1;
        cyc++;
        for (int ch = 0; ch < NCH; ch++) begin
            check($sformatf("thrust%0d", ch), th(ch), mv[ch]);
            check($sformatf("at_max%0d", ch), int'(at_max[ch]), int'(mv[ch] == MX));
            check($sformatf("at_min%0d", ch), int'(at_min[ch]), int'(mv[ch] == 0));
        end
        check("thrust_b", int'(thrust_b), mvb);
        @(negedge clk_sys);
    endtask

    // Run clocks until one tick has been applied.
    task automatic tick_edge();
        bit was;
        for (int i = 0; i < 2 * TD; i++) begin
            was = ((cyc % TD) == TD - 1);
            cycle();
            if (was) break;
        end
    endtask

    abs_vec_t vecs[6];

    initial begin
        vecs[0] = '{-128, 254, 1000};
        vecs[1] = '{0,    127, 508};
        vecs[2] = '{127,  0,   0};
        vecs[3] = '{107,  20,  80};
        vecs[4] = '{-1,   128, 512};
        vecs[5] = '{64,   63,  252};

        RESET_L = 1'b1; mode = '0; key_up = '0; key_down = '0; axis = '0;
        mode_b = 2'b00; key_up_b = '0; key_down_b = '0; axis_b = 8'd127;
        #1 RESET_L = 1'b0;
        #11;
        check("rst_thrust", int'(thrust), 0);
        check("rst_at_min", int'(at_min), 3);
        check("rst_at_max", int'(at_max), 0);
        check("rst_tick", int'(tick), 0);
        for (int ch = 0; ch < NCH; ch++) mv[ch] = 0;
        mvb = 0;
        @(negedge clk_sys);
        RESET_L = 1'b1;
        cyc = 0;

        // Absolute table: result appears one clock after it is presented.
        for (int i = 0; i < 6; i++) begin
            int prev;
            prev = th(0);
            set_axis(0, vecs[i].ax);
            set_axis(1, vecs[i].ax);
            axis_b = 8'(vecs[i].ax);
            #1 check("abs_latency", th(0), prev);
            cycle();
            check($sformatf("abs_ax%0d", vecs[i].ax), th(0), vecs[i].exp8);
            check($sformatf("abs10_ax%0d", vecs[i].ax), int'(thrust_b), vecs[i].exp10);
        end

        // D-pad ramp on ch0 while ch1 tracks a random stick in absolute mode.
        set_axis(0, 127);
        cycle();
        mode[1:0] = 2'b01; key_up[0] = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            set_axis(1, int'($urandom_range(0, 255)));
            tick_edge();
            check("ramp_up", th(0), (k < MX) ? k : MX);
        end
        check("ramp_at_max", int'(at_max[0]), 1);
        key_down[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick_edge();
            check("ramp_both", th(0), MX);
        end
        key_up[0] = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            tick_edge();
            check("ramp_down", th(0), (MX - k > 0) ? MX - k : 0);
        end
        check("ramp_at_min", int'(at_min[0]), 1);
        key_down[0] = 1'b0;

        // Analog rate on ch0.
        mode[1:0] = 2'b00; set_axis(0, 107);
        cycle();
        mode[1:0] = 2'b10; set_axis(0, 8);
        for (int k = 0; k < 3; k++) begin
            tick_edge();
            check("rate_dead", th(0), 20);
        end
        set_axis(0, -64);
        for (int k = 1; k <= 3; k++) begin
            tick_edge();
            check("rate_up", th(0), 20 + 5 * k);
        end
        mode[1:0] = 2'b00; set_axis(0, 107);
        cycle();
        mode[1:0] = 2'b10; set_axis(0, 127);
        for (int k = 1; k <= 3; k++) begin
            tick_edge();
            check("rate_down", th(0), (20 - 8 * k > 0) ? 20 - 8 * k : 0);
        end

        // Spring-return on ch0.
        mode[1:0] = 2'b00; set_axis(0, 117);
        cycle();
        mode[1:0] = 2'b11;
        for (int k = 1; k <= 12; k++) begin
            tick_edge();
            check("spring_decay", th(0), (10 - k > 0) ? 10 - k : 0);
        end
        key_up[0] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick_edge();
            check("spring_up", th(0), k);
        end
        key_up[0] = 1'b0; key_down[0] = 1'b1;
        tick_edge();
        check("spring_dn1", th(0), 1);
        tick_edge();
        check("spring_dn2", th(0), 0);
        key_down[0] = 1'b0;

        // ch1 switches from absolute to ramp and continues from its value.
        mode = 4'b0001; set_axis(1, 0);
        cycle();
        check("switch_abs", th(1), 127);
        mode[3:2] = 2'b01; key_up[1] = 1'b1;
        tick_edge();
        check("switch_128", th(1), 128);
        tick_edge();
        check("switch_129", th(1), 129);
        key_up[1] = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ((i % 40) == 0) begin
                mode   = 4'($urandom_range(0, 15));
                mode_b = 2'($urandom_range(0, 3));
            end
            key_up     = 2'($urandom);
            key_down   = 2'($urandom);
            axis       = 16'($urandom);
            key_up_b   = 1'($urandom);
            key_down_b = 1'($urandom);
            axis_b     = 8'($urandom);
            cycle();
        end

        // Reset asserted mid-ramp clears immediately.
        mode = 4'b0101; key_up = 2'b11; key_down = '0; mode_b = 2'b00;
        for (int k = 0; k < 5; k++) tick_edge();
        #2 RESET_L = 1'b0;
        #1;
        check("mid_rst_thrust", int'(thrust), 0);
        check("mid_rst_thrust_b", int'(thrust_b), 0);
        check("mid_rst_at_min", int'(at_min), 3);
        check("mid_rst_at_max", int'(at_max), 0);
        check("mid_rst_tick", int'(tick), 0);
        for (int ch = 0; ch < NCH; ch++) mv[ch] = 0;
        mvb = 0;
        @(posedge clk_sys);
        #1 check("rst_hold", int'(thrust), 0);
        @(negedge clk_sys);
        RESET_L = 1'b1;
        cyc = 0;
        for (int k = 0; k < 10; k++) begin
            if (cyc == TD - 1) check("first_tick", int'(tick), 1);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
